// File: rtl/tmds_serializer_mc_if.sv
// Bus bundle for the multi-channel TMDS serializer.
// master: drives en/par_data/bitslip and receives par_ready/frame_start/ser_rise/ser_fall.
// slave: the serializer side.
interface tmds_serializer_mc_if #(
    parameter int WIDTH    = 10,
    parameter int CHANNELS = 3
);
    logic                      en;
    logic [CHANNELS*WIDTH-1:0] par_data;
    logic [CHANNELS-1:0]       bitslip;
    logic                      par_ready;
    logic                      frame_start;
    logic [CHANNELS-1:0]       ser_rise;
    logic [CHANNELS-1:0]       ser_fall;

    modport master (
        output en, par_data, bitslip,
        input  par_ready, frame_start, ser_rise, ser_fall
    );

    modport slave (
        input  en, par_data, bitslip,
        output par_ready, frame_start, ser_rise, ser_fall
    );
endinterface

// File: rtl/tmds_serializer_mc.sv
// Multi-channel TMDS parallel-to-serial engine with per-lane bitslip,
// selectable bit order and DDR (rise/fall pair) or SDR output slots.
// Ports: sys_clk (serial-rate clock), sys_rst_n (sync active-low reset),
//   bus (slave): en, par_data, bitslip in; par_ready, frame_start,
//   ser_rise, ser_fall out.
module tmds_serializer_mc #(
    parameter int WIDTH     = 10,
    parameter int CHANNELS  = 3,
    parameter int DDR       = 1,
    parameter int MSB_FIRST = 0
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    tmds_serializer_mc_if.slave  bus
);
    localparam int SLOTS = (DDR != 0) ? WIDTH / 2 : WIDTH;
    localparam int CW    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int SW    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int BPS   = (DDR != 0) ? 2 : 1;
    localparam logic [CW-1:0] LAST  = CW'(SLOTS - 1);
    localparam logic [SW-1:0] SLIPM = SW'(WIDTH - 1);

    if (WIDTH < 2) begin : g_bad_width
        $error("tmds_serializer_mc: WIDTH must be at least 2");
    end
    if (CHANNELS < 1) begin : g_bad_channels
        $error("tmds_serializer_mc: CHANNELS must be at least 1");
    end
    if ((DDR != 0) && (WIDTH % 2 != 0)) begin : g_bad_ddr
        $error("tmds_serializer_mc: DDR needs an even WIDTH");
    end

    logic [CW-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]    sh_q   [CHANNELS];
    logic [WIDTH-1:0]    sh_d   [CHANNELS];
    logic [SW-1:0]       slip_q [CHANNELS];
    logic [SW-1:0]       slip_d [CHANNELS];
    logic [CHANNELS-1:0] rise_q, rise_d;
    logic [CHANNELS-1:0] fall_q, fall_d;
    logic                fs_q, fs_d;
    logic                load;

    // Optional bit reversal, then rotate right by the slip offset so
    // that bit 0 of the result is the first bit on the wire.
    function automatic logic [WIDTH-1:0] xform(
        input logic [WIDTH-1:0] w,
        input logic [SW-1:0]    s
    );
        logic [WIDTH-1:0]   t;
        logic [2*WIDTH-1:0] dbl;
        for (int i = 0; i < WIDTH; i++) begin
            t[i] = (MSB_FIRST != 0) ? w[WIDTH-1-i] : w[i];
        end
        dbl = {t, t} >> s;
        return dbl[WIDTH-1:0];
    endfunction

    assign load = bus.en && (cnt_q == LAST);

    always_comb begin
        logic [WIDTH-1:0] nxt;
        nxt    = '0;
        cnt_d  = cnt_q;
        rise_d = rise_q;
        fall_d = fall_q;
        fs_d   = fs_q;
        for (int c = 0; c < CHANNELS; c++) begin
            sh_d[c]   = sh_q[c];
            slip_d[c] = slip_q[c];
            // Slip is tracked even while disabled; a load in the same
            // cycle still uses the old offset.
            if (bus.bitslip[c]) begin
                slip_d[c] = (slip_q[c] == SLIPM) ? '0 : slip_q[c] + SW'(1);
            end
        end
        if (!bus.en) begin
            cnt_d  = LAST;
            rise_d = '0;
            fall_d = '0;
            fs_d   = 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                sh_d[c] = '0;
            end
        end else begin
            cnt_d = load ? '0 : cnt_q + CW'(1);
            fs_d  = load;
            // The head slot goes straight to the output flops; the
            // shift register keeps only the slots still to come.
            for (int c = 0; c < CHANNELS; c++) begin
                nxt = load ? xform(bus.par_data[c*WIDTH +: WIDTH], slip_q[c])
                           : sh_q[c];
                rise_d[c] = nxt[0];
                fall_d[c] = nxt[BPS-1];
                sh_d[c]   = nxt >> BPS;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            cnt_q  <= LAST;
            rise_q <= '0;
            fall_q <= '0;
            fs_q   <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                sh_q[c]   <= '0;
                slip_q[c] <= '0;
            end
        end else begin
            cnt_q  <= cnt_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            fs_q   <= fs_d;
            for (int c = 0; c < CHANNELS; c++) begin
                sh_q[c]   <= sh_d[c];
                slip_q[c] <= slip_d[c];
            end
        end
    end

    assign bus.par_ready   = sys_rst_n & load;
    assign bus.frame_start = fs_q;
    assign bus.ser_rise    = rise_q;
    assign bus.ser_fall    = fall_q;
endmodule

// File: tb/tb_tmds_serializer_mc.sv
// Testbench for tmds_serializer_mc: a DDR 10-bit 3-lane instance and an
// SDR 8-bit MSB-first 1-lane instance against a slot-queue model.
module tb_tmds_serializer_mc;
    logic        sys_clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [29:0] par0;
    logic [2:0]  bs0;
    logic [7:0]  par1;
    logic [0:0]  bs1;

    int compared   = 0;
    int mismatched = 0;

    tmds_serializer_mc_if #(.WIDTH(10), .CHANNELS(3)) bus0 ();
    tmds_serializer_mc_if #(.WIDTH(8),  .CHANNELS(1)) bus1 ();

    assign bus0.en       = en;
    assign bus0.par_data = par0;
    assign bus0.bitslip  = bs0;
    assign bus1.en       = en;
    assign bus1.par_data = par1;
    assign bus1.bitslip  = bs1;

    tmds_serializer_mc #(
        .WIDTH(10), .CHANNELS(3), .DDR(1), .MSB_FIRST(0)
    ) dut0 (
        .sys_clk   (sys_clk),
        .sys_rst_n (rst_n),
        .bus       (bus0)
    );

    tmds_serializer_mc #(
        .WIDTH(8), .CHANNELS(1), .DDR(0), .MSB_FIRST(1)
    ) dut1 (
        .sys_clk   (sys_clk),
        .sys_rst_n (rst_n),
        .bus       (bus1)
    );

    always #5 sys_clk = ~sys_clk;

    // ---------------- reference model ----------------
    // Each load pushes one entry per output slot; each enabled cycle
    // pops one. A load happens whenever the previous word is used up.
    bit [5:0] q0[$];
    bit [1:0] q1[$];
    int       slip0[3];
    int       slip1;
    bit [2:0] e_r0, e_f0;
    bit       e_fs0;
    bit       e_r1, e_f1, e_fs1;

    function automatic bit tbit(bit [15:0] word, int w, int msb, int p);
        return (msb != 0) ? word[w-1-p] : word[p];
    endfunction

    // {fall, rise} of slot k for a word under the given slip offset
    function automatic bit [1:0] slot_bits(bit [15:0] word, int w,
                                           int ddr, int msb,
                                           int slip, int k);
        int jr;
        int jf;
        jr = (ddr != 0) ? 2 * k : k;
        jf = (ddr != 0) ? 2 * k + 1 : k;
        return {tbit(word, w, msb, (jf + slip) % w),
                tbit(word, w, msb, (jr + slip) % w)};
    endfunction

    task automatic model_step();
        bit [5:0] ent;
        bit [1:0] s;
        bit       ld0;
        bit       ld1;
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            for (int c = 0; c < 3; c++) slip0[c] = 0;
            slip1 = 0;
            e_r0 = 0; e_f0 = 0; e_fs0 = 0;
            e_r1 = 0; e_f1 = 0; e_fs1 = 0;
            return;
        end
        if (!en) begin
            q0.delete();
            q1.delete();
            e_r0 = 0; e_f0 = 0; e_fs0 = 0;
            e_r1 = 0; e_f1 = 0; e_fs1 = 0;
        end else begin
            ld0 = (q0.size() == 0);
            ld1 = (q1.size() == 0);
            if (ld0) begin
                for (int k = 0; k < 5; k++) begin
                    ent = '0;
                    for (int c = 0; c < 3; c++) begin
                        ent[2*c +: 2] = slot_bits(16'(par0[c*10 +: 10]),
                                                  10, 1, 0, slip0[c], k);
                    end
                    q0.push_back(ent);
                end
            end
            if (ld1) begin
                for (int k = 0; k < 8; k++) begin
                    q1.push_back(slot_bits(16'(par1), 8, 0, 1, slip1, k));
                end
            end
            ent = q0.pop_front();
            for (int c = 0; c < 3; c++) begin
                e_r0[c] = ent[2*c];
                e_f0[c] = ent[2*c+1];
            end
            s = q1.pop_front();
            e_r1  = s[0];
            e_f1  = s[1];
            e_fs0 = ld0;
            e_fs1 = ld1;
        end
        for (int c = 0; c < 3; c++) begin
            if (bs0[c]) slip0[c] = (slip0[c] + 1) % 10;
        end
        if (bs1[0]) slip1 = (slip1 + 1) % 8;
    endtask

    initial forever begin
        @(posedge sys_clk);
        model_step();
    end

    // ---------------- checking ----------------
    task automatic chk(string name, int got, int exp);
        compared++;
        if (got != exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     name, got, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge sys_clk);
        chk("m0_rise",  int'(bus0.ser_rise),    int'(e_r0));
        chk("m0_fall",  int'(bus0.ser_fall),    int'(e_f0));
        chk("m0_fs",    int'(bus0.frame_start), int'(e_fs0));
        chk("m0_ready", int'(bus0.par_ready),
            int'(rst_n && en && q0.size() == 0));
        chk("m1_rise",  int'(bus1.ser_rise),    int'(e_r1));
        chk("m1_fall",  int'(bus1.ser_fall),    int'(e_f1));
        chk("m1_fs",    int'(bus1.frame_start), int'(e_fs1));
        chk("m1_ready", int'(bus1.par_ready),
            int'(rst_n && en && q1.size() == 0));
    end

    // ---------------- stimulus helpers ----------------
    bit [9:0] g_r0, g_f0, g_r1, g_f1, g_fs, g_pr;
    bit [9:0] g_rb, g_fb, g_prb;

    task automatic cyc();
        @(posedge sys_clk);
        #2;
    endtask

    // Record n output slots, bit k = slot k.
    task automatic grab(input int n);
        g_r0 = 0; g_f0 = 0; g_r1 = 0; g_f1 = 0; g_fs = 0; g_pr = 0;
        g_rb = 0; g_fb = 0; g_prb = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge sys_clk);
            g_r0[k]  = bus0.ser_rise[0];
            g_f0[k]  = bus0.ser_fall[0];
            g_r1[k]  = bus0.ser_rise[1];
            g_f1[k]  = bus0.ser_fall[1];
            g_fs[k]  = bus0.frame_start;
            g_pr[k]  = bus0.par_ready;
            g_rb[k]  = bus1.ser_rise[0];
            g_fb[k]  = bus1.ser_fall[0];
            g_prb[k] = bus1.par_ready;
            cyc();
        end
    endtask

    // Run until just past the next load edge of instance 0.
    task automatic wait_load(string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge sys_clk);
            found = bus0.par_ready;
            cyc();
        end
        chk({name, "_load_seen"}, int'(found), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; en = 1'b0;
        par0 = '0; bs0 = '0; par1 = '0; bs1 = '0;
        repeat (3) cyc();

        // reset state
        @(negedge sys_clk);
        chk("rst_rise",  int'(bus0.ser_rise),    0);
        chk("rst_fall",  int'(bus0.ser_fall),    0);
        chk("rst_fs",    int'(bus0.frame_start), 0);
        chk("rst_ready", int'(bus0.par_ready),   0);
        cyc();

        // basic DDR word, ch0/ch1 = 0x34E
        rst_n = 1'b1; en = 1'b1;
        par0 = {10'h155, 10'h34E, 10'h34E};
        @(negedge sys_clk);
        chk("s1_first_ready", int'(bus0.par_ready), 1);
        cyc();
        grab(5);
        chk("s1_rise", int'(g_r0), 'h1A);
        chk("s1_fall", int'(g_f0), 'h13);
        chk("s1_fs",   int'(g_fs), 'h01);
        chk("s1_ready_period", int'(g_pr), 'h10);

        // one bitslip mid-frame on ch0, takes effect next frame
        bs0 = 3'b001;
        cyc();
        bs0 = 3'b000;
        wait_load("s2");
        grab(5);
        chk("s2_rise",     int'(g_r0), 'h13);
        chk("s2_fall",     int'(g_f0), 'h0D);
        chk("s2_ch1_rise", int'(g_r1), 'h1A);
        chk("s2_ch1_fall", int'(g_f1), 'h13);

        // nine more pulses wrap the offset back to 0
        for (int i = 0; i < 9; i++) begin
            bs0 = 3'b001;
            cyc();
            bs0 = 3'b000;
            cyc();
        end
        wait_load("s2w");
        grab(5);
        chk("s2_wrap_rise", int'(g_r0), 'h1A);
        chk("s2_wrap_fall", int'(g_f0), 'h13);

        // gapless word stream
        par0[9:0] = 10'h3FF;
        wait_load("s3");
        par0[9:0] = 10'h000;
        grab(5);
        chk("s3_ones_rise", int'(g_r0), 'h1F);
        chk("s3_ones_fall", int'(g_f0), 'h1F);
        chk("s3_ones_fs",   int'(g_fs), 'h01);
        par0[9:0] = 10'h2AA;
        grab(5);
        chk("s3_zero_rise", int'(g_r0), 'h00);
        chk("s3_zero_fall", int'(g_f0), 'h00);
        chk("s3_zero_fs",   int'(g_fs), 'h01);
        par0[9:0] = 10'($urandom);
        grab(5);
        chk("s3_alt_rise", int'(g_r0), 'h00);
        chk("s3_alt_fall", int'(g_f0), 'h1F);
        chk("s3_alt_fs",   int'(g_fs), 'h01);

        // abort at slot 2, slip offset must survive
        bs0 = 3'b001;
        cyc();
        bs0 = 3'b000;
        par0[9:0] = 10'h34E;
        wait_load("s4");
        cyc();
        cyc();
        en = 1'b0;
        cyc();
        @(negedge sys_clk);
        chk("s4_abort_rise",  int'(bus0.ser_rise),    0);
        chk("s4_abort_fall",  int'(bus0.ser_fall),    0);
        chk("s4_abort_fs",    int'(bus0.frame_start), 0);
        chk("s4_abort_ready", int'(bus0.par_ready),   0);
        cyc();
        en = 1'b1;
        @(negedge sys_clk);
        chk("s4_reen_ready", int'(bus0.par_ready), 1);
        cyc();
        grab(5);
        chk("s4_rise", int'(g_r0), 'h13);
        chk("s4_fall", int'(g_f0), 'h0D);
        chk("s4_fs",   int'(g_fs), 'h01);

        // reset mid-frame with a simultaneous bitslip
        cyc();
        rst_n = 1'b0;
        bs0 = 3'b001;
        cyc();
        rst_n = 1'b1;
        bs0 = 3'b000;
        @(negedge sys_clk);
        chk("s5_rst_rise",  int'(bus0.ser_rise),    0);
        chk("s5_rst_fall",  int'(bus0.ser_fall),    0);
        chk("s5_rst_fs",    int'(bus0.frame_start), 0);
        chk("s5_rst_ready", int'(bus0.par_ready),   1);
        cyc();
        grab(5);
        chk("s5_rise", int'(g_r0), 'h1A);
        chk("s5_fall", int'(g_f0), 'h13);

        // randomized traffic, checked cycle by cycle against the model
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            en    = ($urandom_range(0, 39) != 0);
            par0  = 30'($urandom);
            par1  = 8'($urandom);
            bs0   = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'b000;
            bs1   = 1'($urandom_range(0, 7) == 0);
            cyc();
        end

        // SDR, MSB first, 8-bit word 0xB4
        rst_n = 1'b0; en = 1'b0; bs0 = '0; bs1 = '0;
        cyc();
        rst_n = 1'b1;
        cyc();
        par1 = 8'hB4;
        en = 1'b1;
        @(negedge sys_clk);
        chk("s6_first_ready", int'(bus1.par_ready), 1);
        cyc();
        grab(8);
        chk("s6_rise",  int'(g_rb),  'h2D);
        chk("s6_fall",  int'(g_fb),  'h2D);
        chk("s6_ready_period", int'(g_prb), 'h80);

        repeat (3) cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end
endmodule

// File: doc/tmds_serializer_mc.md
Name: tmds_serializer_mc

Overview:
- Multi-channel parallel-to-serial engine for the HDMI/TMDS transmit path. Runs in the 5x (or 10x) pixel-rate domain.
- Each channel converts a WIDTH-bit word into a stream of per-cycle rise/fall bit pairs (DDR) or single bits (SDR). These drive external DDIO output primitives.
- Adds per-channel bitslip alignment, selectable bit order, enable/abort, and a word-sampled strobe for upstream logic.

Parameters:
- WIDTH, 10: bits per word per channel; >=2; must be even when DDR=1.
- CHANNELS, 3: number of independent lanes.
- DDR, 1: 1 = two bits per cycle (rise/fall); 0 = one bit per cycle.
- MSB_FIRST, 0: 0 = transmit word bit 0 first; 1 = transmit bit WIDTH-1 first.

Ports:
- sys_clk  input  1  serial-rate clock; all logic on its rising edge.
- sys_rst_n  input  1  synchronous active-low reset.
- en  input  1  serializer enable; low aborts and idles.
- par_data  input  CHANNELS*WIDTH  channel c at [c*WIDTH +: WIDTH]; sampled only on load cycles.
- bitslip  input  CHANNELS  per-channel one-cycle pulse; advances that channel's slip offset by one bit.
- par_ready  output  1  high on load cycles (the cycle par_data is sampled).
- frame_start  output  1  high during the first output slot of each word.
- ser_rise  output  CHANNELS  bit driven on the DDIO high phase.
- ser_fall  output  CHANNELS  bit driven on the DDIO low phase; equals ser_rise when DDR=0.

Behaviour:
- SLOTS = WIDTH/2 if DDR else WIDTH. Slot counter cnt is $clog2(SLOTS) bits (min 1). slip_c is 0..WIDTH-1, one per channel.
- Reset (sys_rst_n=0 at a clock edge): cnt=SLOTS-1, shift registers=0, slip_c=0, all outputs 0.
- en=0 (no reset): same as reset, except slip_c holds. A frame in flight is discarded immediately.
- Load cycle: en=1 and cnt==SLOTS-1. Then cnt<=0, par_ready=1 (combinational from cnt/en), and every channel loads its shift register from par_data. Otherwise cnt<=cnt+1 and shift registers shift down one slot.
- The first enabled cycle after reset or after en low is always a load cycle.
- Word transform, per channel:
  - t = MSB_FIRST ? bit-reverse(word) : word.
  - r = t rotated right by slip_c, so r[i] = t[(i+slip_c) mod WIDTH].
  - r[0] is transmitted first.
- DDR slot k: rise = r[2k], fall = r[2k+1]. SDR slot k: rise = fall = r[k].
- ser_rise/ser_fall are the registered head of each shift register.
- Latency: a word sampled at load edge N appears on slot 0 in cycle N+1 and finishes in cycle N+SLOTS. Back-to-back words are gapless.
- frame_start is registered: high exactly in cycle N+1 of each word, otherwise 0.
- bitslip[c] pulse: slip_c <= (slip_c+1) mod WIDTH, wrapping from WIDTH-1 to 0. Multiple pulses within one frame accumulate.
- bitslip on a load cycle: that load uses the old slip_c; the new value applies from the next load. The frame in flight is never altered.
- bitslip while en=0 is still applied to slip_c.
- par_data outside load cycles is ignored, and may change freely.
- Reset asserted mid-frame overrides en and bitslip in the same cycle.
- Elaboration must fail ($error/assertion) if WIDTH<2, CHANNELS<1, or DDR=1 with odd WIDTH.

Test Plan:
- WIDTH=10, CHANNELS=3, DDR=1, ch0 word 0x34E. Assert en after reset; first cycle is load (par_ready=1). Following 5 cycles: ser_rise[0] = 0,1,0,1,1 and ser_fall[0] = 1,1,0,0,1. frame_start=1 on the first of those cycles only. par_ready repeats every 5 cycles.
- Same word, one bitslip[0] pulse mid-frame. Current frame unchanged. Next frame: rise = 1,1,0,0,1, fall = 1,0,1,1,0. Ch1/ch2 unaffected. Ten pulses total return to the original sequence (wrap).
- Word stream 0x3FF, 0x000, 0x2AA with no gaps. Output: rise/fall all 1 for 5 cycles, all 0 for 5 cycles, then rise=0,0,0,0,0 and fall=1,1,1,1,1. No idle slot between words.
- Drop en at slot 2 of a frame. Next cycle: outputs 0, frame_start 0. Re-raise en: load on the first enabled cycle, full word out; slip_c preserved.
- Assert sys_rst_n=0 mid-frame together with a bitslip pulse. Next cycle: all outputs 0 and slip_c=0. After release, behaviour matches the first scenario.
- WIDTH=8, DDR=0, MSB_FIRST=1, word 0xB4. Serial bits on 8 consecutive cycles: 1,0,1,1,0,1,0,0, with ser_fall equal to ser_rise every cycle. par_ready every 8 cycles.
